// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and address-decode helpers for the banked data memory
package mem_pkg;

    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int BYTE_LANES = 4;
    // Tags are carried at this fixed width internally; ports narrower than this are zero-extended.
    localparam int TAG_MAX_W  = 8;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_W-1:0]     addr;
        logic [BYTE_LANES-1:0] we;
        logic [WORD_W-1:0]     din;
        logic [TAG_MAX_W-1:0]  tag;
    } mem_req_t;

    typedef struct packed {
        logic                 valid;
        logic [WORD_W-1:0]    dout;
        logic [TAG_MAX_W-1:0] tag;
        logic                 err;
    } mem_resp_t;

    function automatic logic [ADDR_W-1:0] row_of(input logic [ADDR_W-1:0] addr,
                                                 input int unsigned row_w);
        return (addr >> 2) & ((32'd1 << row_w) - 32'd1);
    endfunction

    function automatic logic [ADDR_W-1:0] bank_of(input logic [ADDR_W-1:0] addr,
                                                  input int unsigned row_w,
                                                  input int unsigned bank_w);
        return (addr >> (2 + row_w)) & ((32'd1 << bank_w) - 32'd1);
    endfunction

    function automatic logic out_of_range(input logic [ADDR_W-1:0] addr,
                                          input int unsigned row_w,
                                          input int unsigned bank_w);
        return ((addr >> (2 + row_w + bank_w)) != '0);
    endfunction

endpackage

// File: rtl/banked_dmem_if.sv
// rtl/banked_dmem_if.sv - per-port request/response bus between EX, the data memory and WB
interface banked_dmem_if
    import mem_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int TAG_W     = 5
);
    logic [NUM_PORTS-1:0]            req_valid;
    logic [NUM_PORTS*ADDR_W-1:0]     req_addr;
    logic [NUM_PORTS*BYTE_LANES-1:0] req_we;
    logic [NUM_PORTS*WORD_W-1:0]     req_din;
    logic [NUM_PORTS*TAG_W-1:0]      req_tag;
    logic [NUM_PORTS-1:0]            resp_valid;
    logic [NUM_PORTS*WORD_W-1:0]     resp_dout;
    logic [NUM_PORTS*TAG_W-1:0]      resp_tag;
    logic [NUM_PORTS-1:0]            resp_err;

    modport master (
        output req_valid, req_addr, req_we, req_din, req_tag,
        input  resp_valid, resp_dout, resp_tag, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_din, req_tag,
        output resp_valid, resp_dout, resp_tag, resp_err
    );
endinterface

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - one memory bank, NUM_PORTS read-first ports with byte enables
module dmem_bank
    import mem_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ROW_W     = 14
) (
    input  logic                                  clk,
    input  logic                                  en_i,
    input  logic [NUM_PORTS-1:0]                  wr_en_i,
    input  logic [NUM_PORTS-1:0][BYTE_LANES-1:0]  we_i,
    input  logic [NUM_PORTS-1:0][ROW_W-1:0]       row_i,
    input  logic [NUM_PORTS-1:0][WORD_W-1:0]      din_i,
    output logic [NUM_PORTS-1:0][WORD_W-1:0]      dout_o
);
    localparam int DEPTH = 1 << ROW_W;

    logic [WORD_W-1:0]                 mem_q [DEPTH];
    logic [NUM_PORTS-1:0][WORD_W-1:0]  dout_q;

    // Ascending port order makes the highest-numbered port win each byte lane.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                dout_q[p] <= mem_q[row_i[p]];
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int l = 0; l < BYTE_LANES; l++) begin
                    if (wr_en_i[p] && we_i[p][l]) begin
                        mem_q[row_i[p]][8*l +: 8] <= din_i[p][8*l +: 8];
                    end
                end
            end
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/banked_dmem.sv
// rtl/banked_dmem.sv - multi-port, multi-bank MEM-stage data memory with tagged, fixed-latency responses
module banked_dmem
    import mem_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int NUM_BANKS  = 8,
    parameter int BANK_WORDS = 16384,
    parameter int READ_LAT   = 2,
    parameter int TAG_W      = 5
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           stall,
    banked_dmem_if.slave   bus
);
    localparam int ROW_W      = $clog2(BANK_WORDS);
    localparam int BANK_BITS  = $clog2(NUM_BANKS);
    localparam int BANK_IDX_W = (BANK_BITS > 0) ? BANK_BITS : 1;

    mem_req_t                                req     [NUM_PORTS];
    logic [NUM_PORTS-1:0]                    oor;
    logic [NUM_PORTS-1:0][ROW_W-1:0]         row;
    logic [NUM_PORTS-1:0][BANK_IDX_W-1:0]    bank;
    logic [NUM_PORTS-1:0][BYTE_LANES-1:0]    we;
    logic [NUM_PORTS-1:0][WORD_W-1:0]        din;
    logic [NUM_BANKS-1:0][NUM_PORTS-1:0]     bank_wr;
    logic [NUM_BANKS-1:0][NUM_PORTS-1:0][WORD_W-1:0] bank_dout;

    mem_resp_t                               s0_d       [NUM_PORTS];
    mem_resp_t                               s0_q       [NUM_PORTS];
    logic [NUM_PORTS-1:0][BANK_IDX_W-1:0]    s0_bank_q;
    mem_resp_t                               s0_full    [NUM_PORTS];
    mem_resp_t                               pipe_q     [READ_LAT][NUM_PORTS];

    always_comb begin
        bank_wr = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            req[p].valid = bus.req_valid[p];
            req[p].addr  = bus.req_addr[ADDR_W*p +: ADDR_W];
            req[p].we    = bus.req_we[BYTE_LANES*p +: BYTE_LANES];
            req[p].din   = bus.req_din[WORD_W*p +: WORD_W];
            req[p].tag   = TAG_MAX_W'(bus.req_tag[TAG_W*p +: TAG_W]);
            oor[p]  = out_of_range(req[p].addr, ROW_W, BANK_BITS);
            row[p]  = ROW_W'(row_of(req[p].addr, ROW_W));
            bank[p] = BANK_IDX_W'(bank_of(req[p].addr, ROW_W, BANK_BITS));
            we[p]   = req[p].we;
            din[p]  = req[p].din;
            if (rstn && !stall && req[p].valid && !oor[p]) begin
                bank_wr[bank[p]][p] = 1'b1;
            end
            s0_d[p].valid = req[p].valid;
            s0_d[p].dout  = '0;
            s0_d[p].tag   = req[p].valid ? req[p].tag : '0;
            s0_d[p].err   = req[p].valid && oor[p];
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        dmem_bank #(
            .NUM_PORTS (NUM_PORTS),
            .ROW_W     (ROW_W)
        ) u_bank (
            .clk     (clk),
            .en_i    (!stall),
            .wr_en_i (bank_wr[b]),
            .we_i    (we),
            .row_i   (row),
            .din_i   (din),
            .dout_o  (bank_dout[b])
        );
    end

    // First stage lines up with the banks' registered read; data is selected by the registered bank index.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                s0_q[p]      <= '0;
                s0_bank_q[p] <= '0;
            end
        end else if (!stall) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                s0_q[p]      <= s0_d[p];
                s0_bank_q[p] <= bank[p];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            s0_full[p]      = s0_q[p];
            s0_full[p].dout = (s0_q[p].valid && !s0_q[p].err) ? bank_dout[s0_bank_q[p]][p] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < READ_LAT; k++) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    pipe_q[k][p] <= '0;
                end
            end
        end else if (!stall) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                pipe_q[0][p] <= s0_full[p];
                for (int k = 1; k < READ_LAT; k++) begin
                    pipe_q[k][p] <= pipe_q[k-1][p];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.resp_valid[p]                 = pipe_q[READ_LAT-1][p].valid;
            bus.resp_dout[WORD_W*p +: WORD_W] = pipe_q[READ_LAT-1][p].dout;
            bus.resp_tag[TAG_W*p +: TAG_W]    = pipe_q[READ_LAT-1][p].tag[TAG_W-1:0];
            bus.resp_err[p]                   = pipe_q[READ_LAT-1][p].err;
        end
    end

endmodule

// File: tb/tb_banked_dmem.sv
// tb/tb_banked_dmem.sv - directed self-checking bench for banked_dmem (2 ports, 8 banks, latency 2)
module tb_banked_dmem;

    logic clk;
    logic rstn;
    logic stall;
    int   n_vec;
    int   n_bad;

    banked_dmem_if #(.NUM_PORTS(2), .TAG_W(5)) bus ();

    banked_dmem #(
        .NUM_PORTS  (2),
        .NUM_BANKS  (8),
        .BANK_WORDS (16384),
        .READ_LAT   (2),
        .TAG_W      (5)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .stall (stall),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic chk_port(input string name, input int p, input logic v,
                            input logic [31:0] d, input logic [4:0] t, input logic e);
        chk({name, ".valid"}, 64'(bus.resp_valid[p]), 64'(v));
        chk({name, ".dout"},  64'(bus.resp_dout[32*p +: 32]), 64'(d));
        chk({name, ".tag"},   64'(bus.resp_tag[5*p +: 5]), 64'(t));
        chk({name, ".err"},   64'(bus.resp_err[p]), 64'(e));
    endtask

    task automatic set_req(input int p, input logic v, input logic [31:0] a,
                           input logic [3:0] w, input logic [31:0] d, input logic [4:0] t);
        bus.req_valid[p]          = v;
        bus.req_addr[32*p +: 32]  = a;
        bus.req_we[4*p +: 4]      = w;
        bus.req_din[32*p +: 32]   = d;
        bus.req_tag[5*p +: 5]     = t;
    endtask

    task automatic idle();
        set_req(0, 1'b0, 32'h0, 4'h0, 32'h0, 5'd0);
        set_req(1, 1'b0, 32'h0, 4'h0, 32'h0, 5'd0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rstn  = 1'b0;
        stall = 1'b0;
        idle();
        step();
        step();
        chk("reset.valid", 64'(bus.resp_valid), 64'h0);
        chk("reset.dout",  64'(bus.resp_dout),  64'h0);
        chk("reset.tag",   64'(bus.resp_tag),   64'h0);
        chk("reset.err",   64'(bus.resp_err),   64'h0);
        rstn = 1'b1;

        // Basic store then load of 0x00010004 (bank 1, row 1)
        set_req(0, 1'b1, 32'h0001_0004, 4'hF, 32'hDEAD_BEEF, 5'd1);
        step();
        set_req(0, 1'b1, 32'h0001_0004, 4'h0, 32'h0, 5'd7);
        step();
        idle();
        step();
        chk("basic.st.valid", 64'(bus.resp_valid), 64'h1);
        chk("basic.st.tag",   64'(bus.resp_tag[4:0]), 64'd1);
        step();
        chk_port("basic.ld", 0, 1'b1, 32'hDEAD_BEEF, 5'd7, 1'b0);

        // Byte enables with highest-port-wins on one word
        set_req(0, 1'b1, 32'h0000_0008, 4'hF, 32'h1122_3344, 5'd0);
        step();
        set_req(0, 1'b1, 32'h0000_0008, 4'b0011, 32'hAAAA_AAAA, 5'd2);
        set_req(1, 1'b1, 32'h0000_0008, 4'b0110, 32'hBBBB_BBBB, 5'd3);
        step();
        idle();
        set_req(0, 1'b1, 32'h0000_0008, 4'h0, 32'h0, 5'd4);
        step();
        idle();
        step();
        chk_port("prio.st0", 0, 1'b1, 32'h1122_3344, 5'd2, 1'b0);
        chk_port("prio.st1", 1, 1'b1, 32'h1122_3344, 5'd3, 1'b0);
        step();
        chk_port("prio.ld", 0, 1'b1, 32'h11BB_BBAA, 5'd4, 1'b0);
        chk_port("prio.bubble", 1, 1'b0, 32'h0, 5'd0, 1'b0);

        // Same-cycle load and store to one word: load sees the old value
        set_req(0, 1'b1, 32'h0000_000C, 4'hF, 32'h9, 5'd0);
        step();
        set_req(0, 1'b1, 32'h0000_000C, 4'h0, 32'h0, 5'd5);
        set_req(1, 1'b1, 32'h0000_000C, 4'hF, 32'h5, 5'd6);
        step();
        idle();
        set_req(0, 1'b1, 32'h0000_000C, 4'h0, 32'h0, 5'd8);
        step();
        idle();
        step();
        chk_port("rf.ld", 0, 1'b1, 32'h9, 5'd5, 1'b0);
        chk_port("rf.st", 1, 1'b1, 32'h9, 5'd6, 1'b0);
        step();
        chk_port("rf.after", 0, 1'b1, 32'h5, 5'd8, 1'b0);

        // Stall with a load in flight; requests offered while stalled are dropped
        set_req(0, 1'b1, 32'h0001_0004, 4'h0, 32'h0, 5'd9);
        step();
        idle();
        step();
        stall = 1'b1;
        set_req(0, 1'b1, 32'h0001_0004, 4'hF, 32'h1234_5678, 5'd10);
        set_req(1, 1'b1, 32'h0000_000C, 4'h0, 32'h0, 5'd11);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.hold.valid", 64'(bus.resp_valid), 64'h0);
        end
        stall = 1'b0;
        idle();
        step();
        chk_port("stall.resp", 0, 1'b1, 32'hDEAD_BEEF, 5'd9, 1'b0);
        stall = 1'b1;
        step();
        step();
        chk_port("stall.frozen", 0, 1'b1, 32'hDEAD_BEEF, 5'd9, 1'b0);
        stall = 1'b0;
        step();
        chk("stall.nolate.valid", 64'(bus.resp_valid), 64'h0);

        // Out-of-range load and store to word 0x20000, which would alias bank 0 row 0
        set_req(0, 1'b1, 32'h0000_0000, 4'hF, 32'h0BAD_C0DE, 5'd0);
        step();
        set_req(0, 1'b1, 32'h0008_0000, 4'h0, 32'h0, 5'd12);
        set_req(1, 1'b1, 32'h0008_0000, 4'hF, 32'hCAFE_F00D, 5'd13);
        step();
        idle();
        step();
        step();
        chk_port("oor.ld", 0, 1'b1, 32'h0, 5'd12, 1'b1);
        chk_port("oor.st", 1, 1'b1, 32'h0, 5'd13, 1'b1);
        set_req(0, 1'b1, 32'h0000_0000, 4'h0, 32'h0, 5'd1);
        set_req(1, 1'b1, 32'h0001_0004, 4'h0, 32'h0, 5'd2);
        step();
        idle();
        step();
        step();
        chk_port("oor.alias", 0, 1'b1, 32'h0BAD_C0DE, 5'd1, 1'b0);
        chk_port("stall.nowrite", 1, 1'b1, 32'hDEAD_BEEF, 5'd2, 1'b0);

        // Reset with loads in flight and a store offered during the reset edge
        set_req(0, 1'b1, 32'h0000_0000, 4'h0, 32'h0, 5'd14);
        set_req(1, 1'b1, 32'h0000_0008, 4'h0, 32'h0, 5'd15);
        step();
        rstn  = 1'b0;
        stall = 1'b1;
        set_req(0, 1'b0, 32'h0, 4'h0, 32'h0, 5'd0);
        set_req(1, 1'b1, 32'h0000_0008, 4'hF, 32'hFFFF_FFFF, 5'd3);
        step();
        chk("rst.valid", 64'(bus.resp_valid), 64'h0);
        chk("rst.dout",  64'(bus.resp_dout),  64'h0);
        chk("rst.tag",   64'(bus.resp_tag),   64'h0);
        chk("rst.err",   64'(bus.resp_err),   64'h0);
        rstn  = 1'b1;
        stall = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst.nolate.valid", 64'(bus.resp_valid), 64'h0);
        end
        set_req(0, 1'b1, 32'h0001_0004, 4'h0, 32'h0, 5'd4);
        set_req(1, 1'b1, 32'h0000_0008, 4'h0, 32'h0, 5'd5);
        step();
        idle();
        step();
        step();
        chk_port("rst.persist0", 0, 1'b1, 32'hDEAD_BEEF, 5'd4, 1'b0);
        chk_port("rst.persist1", 1, 1'b1, 32'h11BB_BBAA, 5'd5, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
